// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state type and
// the helper that sizes the bit counter.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit-counter width for a WIDTH-bit operand; WIDTH is at least 2.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/fs_bit.sv
// Combinational full-subtractor cell: d = x - y - bin, with borrow out.
module fs_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one fs_bit cell reused per cycle.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf_q;
`endif

  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] r_d;

  fs_bit u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_d)
  );

  assign r_d = {d_bit, r_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SHIFT;
            a_sh_q  <= a;
            b_sh_q  <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          r_q    <= r_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            diff_q  <= r_d;
            bout_q  <= br_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // Borrow into the MSB is br_q on this edge; borrow out is br_d.
            ovf_q   <= br_q ^ br_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference.
// Build with SERIAL_SUBTRACTOR_OVF_EN defined to also check ovf.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Last result the DUT should be presenting; diff/bout must hold it.
  logic [W-1:0] held_diff = '0;
  logic         held_bout = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts an operation at the current negedge (DUT must be IDLE or DONE)
  // and returns at the negedge of the DONE cycle. With hold set, start stays
  // high through SHIFT with different operands, which must be ignored.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    int unsigned  busy_cnt;
    int unsigned  n;
    int           sx, sy, sr;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    exp_diff = x - y;
    exp_bout = (x < y);
    sx = $signed(x);
    sy = $signed(y);
    sr = sx - sy;
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    if (hold) begin
      a = ~x;
      b = x ^ y;
    end else begin
      start = 1'b0;
    end
    check("diff_held_during_op", diff, held_diff);
    busy_cnt = 0;
    n = 0;
    while (!done && n < 3 * W) begin
      if (busy) busy_cnt++;
      if (hold && busy_cnt == W) start = 1'b0;
      n++;
      @(negedge clk);
    end
    check("done_seen", done, 1'b1);
    check("busy_cycles", busy_cnt, W);
    check("done_latency", n + 1, W + 1);
    check("busy_low_in_done", busy, 1'b0);
    check("diff", diff, exp_diff);
    check("bout", bout, exp_bout);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("ovf", ovf, (sr < -(2 ** (W - 1)) || sr > 2 ** (W - 1) - 1));
`endif
    held_diff = exp_diff;
    held_bout = exp_bout;
  endtask

  task automatic after_done_idle();
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    check("idle_not_busy", busy, 1'b0);
    check("diff_hold_idle", diff, held_diff);
    check("bout_hold_idle", bout, held_bout);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    @(negedge clk);

    run_op(8'd100, 8'd37, 1'b0);  after_done_idle();
    run_op(8'd5,   8'd9,  1'b0);  after_done_idle();
    run_op(8'd0,   8'd0,  1'b0);  after_done_idle();
    run_op(8'd255, 8'd255, 1'b0); after_done_idle();
    run_op(8'd0,   8'd255, 1'b0); after_done_idle();
    run_op(8'h80,  8'h01, 1'b0);  after_done_idle();
    run_op(8'h05,  8'h03, 1'b0);  after_done_idle();
    run_op(8'h7F,  8'hFF, 1'b0);  after_done_idle();

    // start held high through SHIFT with changing operands
    run_op(8'd200, 8'd13, 1'b1);  after_done_idle();

    // back-to-back: start asserted in the DONE cycle
    run_op(8'd17, 8'd99, 1'b0);
    run_op(8'd99, 8'd17, 1'b0);
    run_op(8'd1,  8'd2,  1'b0);
    after_done_idle();

    // reset in cycle 4 of an operation
    a = 8'd77;
    b = 8'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_diff", diff, 0);
    check("midrst_bout", bout, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("midrst_ovf", ovf, 1'b0);
`endif
    held_diff = '0;
    held_bout = 1'b0;
    @(negedge clk);
    run_op(8'd42, 8'd43, 1'b0);
    after_done_idle();

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] rx, ry;
      rx = W'($urandom_range(0, 2 ** W - 1));
      ry = W'($urandom_range(0, 2 ** W - 1));
      run_op(rx, ry, 1'b0);
      if ($urandom_range(0, 1) == 0) after_done_idle();
    end
    after_done_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor, LSB first. It is the inverse companion of the combinational full-adder cell.
- One full-subtractor bit cell is reused over WIDTH clock cycles. A single borrow flip-flop carries the borrow between bits.
- Used where area matters more than latency. It sits beside the adder datapath and is driven by a simple start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; operands sampled in the same cycle when accepted
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
busy  output  1  high while bits are being processed
done  output  1  single-cycle pulse; diff/bout valid
diff  output  WIDTH  registered result, a - b mod 2^WIDTH
bout  output  1  final borrow out (1 when a < b unsigned)

Behaviour:
- Interface (decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, diff=0, bout=0. Internal shift registers, borrow and counter are all cleared.
- Reset mid-operation wins: the operation is aborted and all outputs show reset values on the next cycle.
- States:
  - IDLE: waiting for start.
  - SHIFT: one bit processed per cycle.
  - DONE: done=1 for exactly one cycle.
- Transitions:
  - IDLE --start--> SHIFT
  - SHIFT --(cnt==WIDTH-1)--> DONE
  - DONE --start--> SHIFT (back-to-back allowed)
  - DONE --!start--> IDLE
- Acceptance: start is accepted only in IDLE or DONE. In SHIFT it is ignored and operands are not resampled.
- On accept: a_sh<=a, b_sh<=b, br<=0, cnt<=0.
- Bit cell per SHIFT cycle, with x=a_sh[0], y=b_sh[0]:
  - d = x^y^br
  - br_n = (~x&y) | (~(x^y)&br)
- Per SHIFT cycle: a_sh and b_sh shift right; d enters a working register r at the MSB and r shifts right; br<=br_n; cnt++.
- Last bit: on the final SHIFT edge, diff<={d, r[WIDTH-1:1]} and bout<=br_n.
- Output update rule: diff and bout change only on that edge (or on reset). They hold their value in all other states.
- Latency: start high in cycle 0 -> busy=1 in cycles 1..WIDTH -> done=1 in cycle WIDTH+1.
- Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- busy = (state==SHIFT); done = (state==DONE). Both are registered-state decodes with no combinational path from start.
- Arithmetic: result is unsigned modulo 2^WIDTH; wrap-around on underflow is signalled by bout.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit).
  - ovf = signed two's-complement overflow = (borrow into MSB) XOR (borrow out of MSB).
  - Captured on the same edge as bout; reset value 0; held like diff.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg:
  - state typedef {IDLE, SHIFT, DONE} (2-bit encoding)
  - counter-width constant expression $clog2(WIDTH)
- Sub-module fs_bit: combinational full-subtractor cell (x, y, bin -> d, bout). Instantiated once; reusable by the team's ripple subtractor.

Test Plan:
- Basic subtract, WIDTH=8: a=100, b=37, start 1 cycle -> busy cycles 1-8, done cycle 9 only, diff=63, bout=0.
- Underflow: a=5, b=9 -> diff=252, bout=1.
- Boundary operands:
  - a=0, b=0 -> diff=0, bout=0.
  - a=255, b=255 -> diff=0, bout=0.
  - a=0, b=255 -> diff=1, bout=1.
- Handshake:
  - start held during SHIFT with new operands -> ignored; first result unchanged.
  - start in the DONE cycle -> second op begins; its done arrives WIDTH+1 cycles later.
- Reset mid-op: rst at cycle 4 of an operation -> next cycle busy=0, done=0, diff=0, bout=0; a later start works normally.
- SERIAL_SUBTRACTOR_OVF_EN build:
  - 0x80-0x01 -> diff=0x7F, ovf=1, bout=0.
  - 0x05-0x03 -> ovf=0.
